// File: rtl/fnd_pkg.sv
// fnd_pkg: shared widths, display limits, conversion-FSM states and input saturation helper
package fnd_pkg;
  localparam int FND_DIGITS = 4;
  localparam int BCD_W = 4;
  localparam int BIN_W = 14;
  localparam int FND_MAX = 9999;
  localparam int BCD_TOT = FND_DIGITS * BCD_W;
  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} conv_state_e;
  function automatic logic [BIN_W-1:0] sat_bin(input logic [BIN_W-1:0] v);
    return v > BIN_W'(FND_MAX) ? BIN_W'(FND_MAX) : v;
  endfunction
endpackage

// File: rtl/fnd_scan_controller_if.sv
// fnd_scan_controller_if: load bus (i_data/i_load) in, busy and scanned digit drive (o_digitSelect/o_value/o_en) out
interface fnd_scan_controller_if;
  import fnd_pkg::*;
  logic [BIN_W-1:0] i_data;
  logic i_load;
  logic o_busy;
  logic [1:0] o_digitSelect;
  logic [BCD_W-1:0] o_value;
  logic o_en;
  modport master(output i_data, i_load, input o_busy, o_digitSelect, o_value, o_en);
  modport slave(input i_data, i_load, output o_busy, o_digitSelect, o_value, o_en);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble; i_start/i_bin in, o_busy (15 cycles), o_done (commit cycle) and o_bcd out
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [BIN_W-1:0]   i_bin,
  output logic               o_busy,
  output logic               o_done,
  output logic [BCD_TOT-1:0] o_bcd
);
  conv_state_e state_q;
  logic [BCD_TOT+BIN_W-1:0] sr_q, adj;
  logic [3:0] cnt_q;
  always_comb begin
    adj = sr_q;
    for (int n = 0; n < FND_DIGITS; n++)
      adj[BIN_W+n*BCD_W +: BCD_W] = sr_q[BIN_W+n*BCD_W +: BCD_W] >= BCD_W'(5) ? sr_q[BIN_W+n*BCD_W +: BCD_W] + BCD_W'(3) : sr_q[BIN_W+n*BCD_W +: BCD_W];
  end
  assign o_bcd = sr_q[BIN_W +: BCD_TOT];
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_start) begin
          state_q <= CONVERT;
          sr_q <= {{BCD_TOT{1'b0}}, sat_bin(i_bin)};
          cnt_q <= '0;
          o_busy <= 1'b1;
        end
        CONVERT: begin
          sr_q <= adj << 1;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(BIN_W-1)) begin
            state_q <= COMMIT;
            o_done <= 1'b1;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: i_clk/i_reset plus slave bus; converts loaded value to BCD and scans 4 FND digits with optional leading-zero blanking
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit LEAD_ZERO_BLANK = 1'b1
) (
  input logic i_clk,
  input logic i_reset,
  fnd_scan_controller_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] cnt_q;
  logic [1:0] idx_q, idx_d;
  logic [BCD_TOT-1:0] disp_q, disp_d, bcd;
  logic [BCD_W-1:0] val_d;
  logic done, tick, en_d;
  bin2bcd_seq u_conv (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_start(bus.i_load),
    .i_bin(bus.i_data),
    .o_busy(bus.o_busy),
    .o_done(done),
    .o_bcd(bcd)
  );
  // outputs are built from next-state index and display so a tick and a commit land together
  always_comb begin
    tick = cnt_q == CW'(REFRESH_DIV-1);
    idx_d = idx_q + 2'(tick);
    disp_d = done ? bcd : disp_q;
    val_d = disp_d[idx_d*BCD_W +: BCD_W];
    en_d = !LEAD_ZERO_BLANK || idx_d == 2'd0 || (disp_d >> (idx_d*BCD_W)) != '0;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      disp_q <= '0;
      bus.o_digitSelect <= '0;
      bus.o_value <= '0;
      bus.o_en <= 1'b1;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
      idx_q <= idx_d;
      disp_q <= disp_d;
      bus.o_digitSelect <= idx_d;
      bus.o_value <= val_d;
      bus.o_en <= en_d;
    end
  end
endmodule
